// File: rtl/qft3_inverse_pipelined.sv
// 3-qubit inverse QFT, fully pipelined, 19-cycle latency, one vector per cycle.
// Amplitudes are signed fixed point with 4 fraction bits (1.0 = 16).
// Stage order: SWAP(q0,q2), H(q0), CROT(-pi/2, c=q0, t=q1), H(q1),
//              CROT(-pi/4, c=q0, t=q2), CROT(-pi/2, c=q1, t=q2), H(q2).
// Valid semantics: in_valid only tags the data on its cycle; there is no
// ready/backpressure. Datapath registers load every cycle, and out_valid is
// in_valid delayed by exactly the datapath latency.

`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

// Hadamard on qubit K: butterfly at W+1 bits, multiply by 11, then >>>4 and
// truncate to W bits. Three register stages for every amplitude.
module qft3i_h_stage #(
    parameter int W = 16,
    parameter int K = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [8*W-1:0] i_r,
    input  logic [8*W-1:0] i_i,
    output logic [8*W-1:0] o_r,
    output logic [8*W-1:0] o_i
);
    localparam int M = 1 << K;
    localparam int P = W + 6;
    localparam logic signed [P-1:0] C_H = P'(11);

    function automatic logic signed [W:0] ext1(input logic signed [W-1:0] v);
        return {v[W-1], v};
    endfunction

    function automatic logic signed [P-1:0] ext6(input logic signed [W:0] v);
        return {{5{v[W]}}, v};
    endfunction

    function automatic logic signed [W-1:0] shr4(input logic signed [P-1:0] v);
        logic signed [P-1:0] s;
        s = v >>> 4;
        return s[W-1:0];
    endfunction

    for (genvar n = 0; n < 8; n++) begin : g_amp
        localparam int A = n & ~M;
        localparam int B = n | M;
        localparam bit IS_DIFF = ((n & M) != 0);

        logic signed [W-1:0] w_ar, w_ai, w_br, w_bi;
        logic signed [W:0]   r_sum_r, r_sum_i;
        logic signed [P-1:0] r_prod_r, r_prod_i;
        logic signed [W-1:0] r_out_r, r_out_i;

        assign w_ar = i_r[A*W +: W];
        assign w_ai = i_i[A*W +: W];
        assign w_br = i_r[B*W +: W];
        assign w_bi = i_i[B*W +: W];

        // Butterfly sum/difference, scale by 11, shift and truncate.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum_r  <= '0;
                r_sum_i  <= '0;
                r_prod_r <= '0;
                r_prod_i <= '0;
                r_out_r  <= '0;
                r_out_i  <= '0;
            end else begin
                if (IS_DIFF) begin
                    r_sum_r <= ext1(w_ar) - ext1(w_br);
                    r_sum_i <= ext1(w_ai) - ext1(w_bi);
                end else begin
                    r_sum_r <= ext1(w_ar) + ext1(w_br);
                    r_sum_i <= ext1(w_ai) + ext1(w_bi);
                end
                r_prod_r <= ext6(r_sum_r) * C_H;
                r_prod_i <= ext6(r_sum_i) * C_H;
                r_out_r  <= shr4(r_prod_r);
                r_out_i  <= shr4(r_prod_i);
            end
        end

        assign o_r[n*W +: W] = r_out_r;
        assign o_i[n*W +: W] = r_out_i;
    end
endmodule

// Controlled phase rotation by (BR, BI): only amplitudes whose control and
// target bits are both 1 are multiplied; the rest are delayed 3 cycles.
module qft3i_crot_stage #(
    parameter int W  = 16,
    parameter int CM = 1,
    parameter int TM = 2,
    parameter int BR = 0,
    parameter int BI = -16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [8*W-1:0] i_r,
    input  logic [8*W-1:0] i_i,
    output logic [8*W-1:0] o_r,
    output logic [8*W-1:0] o_i
);
    localparam int P = 2 * W;
    localparam logic signed [P-1:0] C_BR = P'(BR);
    localparam logic signed [P-1:0] C_BI = P'(BI);

    function automatic logic signed [P-1:0] ext2(input logic signed [W-1:0] v);
        return {{W{v[W-1]}}, v};
    endfunction

    function automatic logic signed [P:0] ext2b(input logic signed [P-1:0] v);
        return {v[P-1], v};
    endfunction

    function automatic logic signed [W-1:0] shr4(input logic signed [P:0] v);
        logic signed [P:0] s;
        s = v >>> 4;
        return s[W-1:0];
    endfunction

    for (genvar n = 0; n < 8; n++) begin : g_amp
        if (((n & CM) != 0) && ((n & TM) != 0)) begin : g_rot
            logic signed [W-1:0] w_ar, w_ai;
            logic signed [P-1:0] r_m_rr, r_m_ii, r_m_ri, r_m_ir;
            logic signed [P:0]   r_p_r, r_p_i;
            logic signed [W-1:0] r_out_r, r_out_i;

            assign w_ar = i_r[n*W +: W];
            assign w_ai = i_i[n*W +: W];

            // Partial products, then combine, then shift and truncate.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_m_rr  <= '0;
                    r_m_ii  <= '0;
                    r_m_ri  <= '0;
                    r_m_ir  <= '0;
                    r_p_r   <= '0;
                    r_p_i   <= '0;
                    r_out_r <= '0;
                    r_out_i <= '0;
                end else begin
                    r_m_rr  <= ext2(w_ar) * C_BR;
                    r_m_ii  <= ext2(w_ai) * C_BI;
                    r_m_ri  <= ext2(w_ar) * C_BI;
                    r_m_ir  <= ext2(w_ai) * C_BR;
                    r_p_r   <= ext2b(r_m_rr) - ext2b(r_m_ii);
                    r_p_i   <= ext2b(r_m_ri) + ext2b(r_m_ir);
                    r_out_r <= shr4(r_p_r);
                    r_out_i <= shr4(r_p_i);
                end
            end

            assign o_r[n*W +: W] = r_out_r;
            assign o_i[n*W +: W] = r_out_i;
        end else begin : g_pass
            logic [W-1:0] r_d1_r, r_d1_i, r_d2_r, r_d2_i, r_d3_r, r_d3_i;

            // Three-cycle delay keeps this amplitude aligned with rotated ones.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d1_r <= '0;
                    r_d1_i <= '0;
                    r_d2_r <= '0;
                    r_d2_i <= '0;
                    r_d3_r <= '0;
                    r_d3_i <= '0;
                end else begin
                    r_d1_r <= i_r[n*W +: W];
                    r_d1_i <= i_i[n*W +: W];
                    r_d2_r <= r_d1_r;
                    r_d2_i <= r_d1_i;
                    r_d3_r <= r_d2_r;
                    r_d3_i <= r_d2_i;
                end
            end

            assign o_r[n*W +: W] = r_d3_r;
            assign o_i[n*W +: W] = r_d3_i;
        end
    end
endmodule

module qft3_inverse_pipelined (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic signed [`TOTAL_WIDTH-1:0] i000_r, i000_i, i001_r, i001_i,
    input  logic signed [`TOTAL_WIDTH-1:0] i010_r, i010_i, i011_r, i011_i,
    input  logic signed [`TOTAL_WIDTH-1:0] i100_r, i100_i, i101_r, i101_i,
    input  logic signed [`TOTAL_WIDTH-1:0] i110_r, i110_i, i111_r, i111_i,
    output logic                           out_valid,
    output logic signed [`TOTAL_WIDTH-1:0] f000_r, f000_i, f001_r, f001_i,
    output logic signed [`TOTAL_WIDTH-1:0] f010_r, f010_i, f011_r, f011_i,
    output logic signed [`TOTAL_WIDTH-1:0] f100_r, f100_i, f101_r, f101_i,
    output logic signed [`TOTAL_WIDTH-1:0] f110_r, f110_i, f111_r, f111_i
);
    localparam int W   = `TOTAL_WIDTH;
    localparam int LAT = 19;

    logic [8*W-1:0] w_swap_r, w_swap_i;
    logic [8*W-1:0] r_s1_r, r_s1_i;
    logic [8*W-1:0] w_s2_r, w_s2_i, w_s3_r, w_s3_i, w_s4_r, w_s4_i;
    logic [8*W-1:0] w_s5_r, w_s5_i, w_s6_r, w_s6_i, w_s7_r, w_s7_i;
    logic [LAT-1:0] r_valid_sr;

    // Index order is packed LSB-first; q0 <-> q2 swap moves 001<->100, 011<->110.
    assign w_swap_r = {i111_r, i011_r, i101_r, i001_r, i110_r, i010_r, i100_r, i000_r};
    assign w_swap_i = {i111_i, i011_i, i101_i, i001_i, i110_i, i010_i, i100_i, i000_i};

    // Swap stage register (one cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_r <= '0;
            r_s1_i <= '0;
        end else begin
            r_s1_r <= w_swap_r;
            r_s1_i <= w_swap_i;
        end
    end

    qft3i_h_stage #(.W(W), .K(0)) u_s2 (
        .clk(clk), .rst_n(rst_n), .i_r(r_s1_r), .i_i(r_s1_i), .o_r(w_s2_r), .o_i(w_s2_i));
    qft3i_crot_stage #(.W(W), .CM(1), .TM(2), .BR(0), .BI(-16)) u_s3 (
        .clk(clk), .rst_n(rst_n), .i_r(w_s2_r), .i_i(w_s2_i), .o_r(w_s3_r), .o_i(w_s3_i));
    qft3i_h_stage #(.W(W), .K(1)) u_s4 (
        .clk(clk), .rst_n(rst_n), .i_r(w_s3_r), .i_i(w_s3_i), .o_r(w_s4_r), .o_i(w_s4_i));
    qft3i_crot_stage #(.W(W), .CM(1), .TM(4), .BR(11), .BI(-11)) u_s5 (
        .clk(clk), .rst_n(rst_n), .i_r(w_s4_r), .i_i(w_s4_i), .o_r(w_s5_r), .o_i(w_s5_i));
    qft3i_crot_stage #(.W(W), .CM(2), .TM(4), .BR(0), .BI(-16)) u_s6 (
        .clk(clk), .rst_n(rst_n), .i_r(w_s5_r), .i_i(w_s5_i), .o_r(w_s6_r), .o_i(w_s6_i));
    qft3i_h_stage #(.W(W), .K(2)) u_s7 (
        .clk(clk), .rst_n(rst_n), .i_r(w_s6_r), .i_i(w_s6_i), .o_r(w_s7_r), .o_i(w_s7_i));

    // Valid tag travels alongside the data through the same number of registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_sr <= '0;
        end else begin
            r_valid_sr <= {r_valid_sr[LAT-2:0], in_valid};
        end
    end

    assign out_valid = r_valid_sr[LAT-1];

    assign f000_r = w_s7_r[0*W +: W];
    assign f000_i = w_s7_i[0*W +: W];
    assign f001_r = w_s7_r[1*W +: W];
    assign f001_i = w_s7_i[1*W +: W];
    assign f010_r = w_s7_r[2*W +: W];
    assign f010_i = w_s7_i[2*W +: W];
    assign f011_r = w_s7_r[3*W +: W];
    assign f011_i = w_s7_i[3*W +: W];
    assign f100_r = w_s7_r[4*W +: W];
    assign f100_i = w_s7_i[4*W +: W];
    assign f101_r = w_s7_r[5*W +: W];
    assign f101_i = w_s7_i[5*W +: W];
    assign f110_r = w_s7_r[6*W +: W];
    assign f110_i = w_s7_i[6*W +: W];
    assign f111_r = w_s7_r[7*W +: W];
    assign f111_i = w_s7_i[7*W +: W];
endmodule

// File: tb/tb_qft3_inverse_pipelined.sv
// Directed bench for qft3_inverse_pipelined: table of hand-computed vectors,
// plus reset, streaming and mid-flight reset sequences.
module tb_qft3_inverse_pipelined;
  localparam int W = 16;
  localparam int LAT = 19;
  localparam int MAX_WAIT = 40;

  typedef struct packed {
    logic [7:0][W-1:0] in_r;
    logic [7:0][W-1:0] in_i;
    logic [7:0][W-1:0] ex_r;
    logic [7:0][W-1:0] ex_i;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [W-1:0] in_r [8];
  logic signed [W-1:0] in_i [8];
  logic signed [W-1:0] out_r [8];
  logic signed [W-1:0] out_i [8];
  logic out_valid;

  vec_t vecs [8];
  int n_vec = 0;
  int t_ir [8];
  int t_ii [8];
  int t_er [8];
  int t_ei [8];
  int exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  qft3_inverse_pipelined dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .i000_r(in_r[0]), .i000_i(in_i[0]), .i001_r(in_r[1]), .i001_i(in_i[1]),
    .i010_r(in_r[2]), .i010_i(in_i[2]), .i011_r(in_r[3]), .i011_i(in_i[3]),
    .i100_r(in_r[4]), .i100_i(in_i[4]), .i101_r(in_r[5]), .i101_i(in_i[5]),
    .i110_r(in_r[6]), .i110_i(in_i[6]), .i111_r(in_r[7]), .i111_i(in_i[7]),
    .out_valid(out_valid),
    .f000_r(out_r[0]), .f000_i(out_i[0]), .f001_r(out_r[1]), .f001_i(out_i[1]),
    .f010_r(out_r[2]), .f010_i(out_i[2]), .f011_r(out_r[3]), .f011_i(out_i[3]),
    .f100_r(out_r[4]), .f100_i(out_i[4]), .f101_r(out_r[5]), .f101_i(out_i[5]),
    .f110_r(out_r[6]), .f110_i(out_i[6]), .f111_r(out_r[7]), .f111_i(out_i[7])
  );

  // scoreboard helpers
  task automatic check_val(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s[%0d] actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  function automatic int count_nonzero();
    int c;
    c = int'(out_valid);
    for (int j = 0; j < 8; j++) begin
      if (out_r[j] != 0) c++;
      if (out_i[j] != 0) c++;
    end
    return c;
  endfunction

  task automatic compare_vec(input int v, input string tag);
    check_val({tag, "_valid"}, v, int'(out_valid), 1);
    for (int j = 0; j < 8; j++) begin
      check_val({tag, "_r"}, j, int'(out_r[j]), int'($signed(vecs[v].ex_r[j])));
      check_val({tag, "_i"}, j, int'(out_i[j]), int'($signed(vecs[v].ex_i[j])));
    end
  endtask

  task automatic add_vec();
    for (int j = 0; j < 8; j++) begin
      vecs[n_vec].in_r[j] = t_ir[j][W-1:0];
      vecs[n_vec].in_i[j] = t_ii[j][W-1:0];
      vecs[n_vec].ex_r[j] = t_er[j][W-1:0];
      vecs[n_vec].ex_i[j] = t_ei[j][W-1:0];
    end
    n_vec++;
  endtask

  // driver tasks
  task automatic drive_vec(input int v);
    for (int j = 0; j < 8; j++) begin
      in_r[j] = $signed(vecs[v].in_r[j]);
      in_i[j] = $signed(vecs[v].in_i[j]);
    end
    in_valid = 1'b1;
    exp_q.push_back(v);
  endtask

  task automatic drive_idle();
    for (int j = 0; j < 8; j++) begin
      in_r[j] = '0;
      in_i[j] = '0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(inout int lat);
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Index order in every row: 000,001,010,011,100,101,110,111.
  task automatic fill_table();
    // |000> real
    t_ir = '{16, 0, 0, 0, 0, 0, 0, 0};  t_ii = '{0, 0, 0, 0, 0, 0, 0, 0};
    t_er = '{4, 4, 4, 4, 4, 4, 4, 4};   t_ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    add_vec();
    // |001> real
    t_ir = '{0, 16, 0, 0, 0, 0, 0, 0};  t_ii = '{0, 0, 0, 0, 0, 0, 0, 0};
    t_er = '{4, 2, 0, -4, -5, -3, 0, 3}; t_ei = '{0, -4, -5, -3, 0, 3, 4, 2};
    add_vec();
    // |100> real
    t_ir = '{0, 0, 0, 0, 16, 0, 0, 0};  t_ii = '{0, 0, 0, 0, 0, 0, 0, 0};
    t_er = '{4, -6, 4, -6, 4, -6, 4, -6}; t_ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    add_vec();
    // -|000>: floor rounding toward -inf
    t_ir = '{-16, 0, 0, 0, 0, 0, 0, 0}; t_ii = '{0, 0, 0, 0, 0, 0, 0, 0};
    t_er = '{-6, -6, -6, -6, -6, -6, -6, -6}; t_ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    add_vec();
    // i|000>
    t_ir = '{0, 0, 0, 0, 0, 0, 0, 0};   t_ii = '{16, 0, 0, 0, 0, 0, 0, 0};
    t_er = '{0, 0, 0, 0, 0, 0, 0, 0};   t_ei = '{4, 4, 4, 4, 4, 4, 4, 4};
    add_vec();
    // i|001>: exercises the cross terms of both rotations
    t_ir = '{0, 0, 0, 0, 0, 0, 0, 0};   t_ii = '{0, 16, 0, 0, 0, 0, 0, 0};
    t_er = '{0, 2, 4, 2, 0, -3, -5, -3}; t_ei = '{4, 2, 0, -3, -5, -3, 0, 2};
    add_vec();
    // large inputs: first butterfly product wraps at 16 bits
    t_ir = '{30000, 0, 0, 0, 30000, 0, 0, 0}; t_ii = '{0, 0, 0, 0, 0, 0, 0, 0};
    t_er = '{-11480, 0, -11480, 0, -11480, 0, -11480, 0}; t_ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    add_vec();
  endtask

  task automatic run_single(input int v);
    int lat;
    int e;
    @(negedge clk);
    drive_vec(v);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    drive_idle();
    wait_valid(lat);
    check_val("latency", v, lat, LAT);
    e = exp_q.pop_front();
    compare_vec(e, "vec");
    @(posedge clk);
    #1;
    check_val("pulse_end", v, int'(out_valid), 0);
  endtask

  task automatic run_stream();
    int lat;
    int e;
    @(negedge clk);
    drive_vec(0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    drive_vec(1);
    @(posedge clk);
    lat = 2;
    @(negedge clk);
    drive_idle();
    wait_valid(lat);
    check_val("stream_latency", 0, lat, LAT);
    e = exp_q.pop_front();
    compare_vec(e, "stream_first");
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare_vec(e, "stream_second");
    @(posedge clk);
    #1;
    check_val("stream_end", 0, int'(out_valid), 0);
  endtask

  task automatic run_midflight_reset();
    @(negedge clk);
    drive_vec(1);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_asserted", 0, count_nonzero(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      check_val("midrst_quiet", c, count_nonzero(), 0);
    end
  endtask

  // main sequence
  initial begin
    fill_table();
    rst_n = 1'b0;
    drive_vec(1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_valid", 0, int'(out_valid), 0);
    for (int j = 0; j < 8; j++) begin
      check_val("reset_r", j, int'(out_r[j]), 0);
      check_val("reset_i", j, int'(out_i[j]), 0);
    end
    drive_idle();
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      check_val("idle_zero", c, count_nonzero(), 0);
    end

    for (int v = 0; v < n_vec; v++) begin
      run_single(v);
    end

    run_stream();
    run_midflight_reset();

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/qft3_inverse_pipelined.md
QFT3_INVERSE_PIPELINED -- requirements
Module: qft3_inverse_pipelined

Interface
REQ-001 Parameters: none; data width SHALL be `TOTAL_WIDTH from fixed_point_params.vh; fixed-point scale SHALL be 1.0 = 16 (4 fraction bits).
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset is asynchronous and active-low.
REQ-004 in_valid  input  1  marks the input vector on this cycle as valid.
REQ-005 iXYZ_r, iXYZ_i (XYZ = 000..111)  input  signed `TOTAL_WIDTH each  amplitudes of the frequency-domain state, bit2 = q2, bit0 = q0.
REQ-006 out_valid  output  1  marks fXYZ outputs as valid.
REQ-007 fXYZ_r, fXYZ_i (XYZ = 000..111)  output  signed `TOTAL_WIDTH each  inverse-QFT amplitudes, registered.

Function
REQ-008 Block SHALL compute the 3-qubit inverse QFT, undoing the forward QFT pipeline, as seven stages in this order: S1 SWAP q0/q2; S2 H on q0; S3 CROT(-pi/2) control q0, target q1; S4 H on q1; S5 CROT(-pi/4) control q0, target q2; S6 CROT(-pi/2) control q1, target q2; S7 H on q2.
REQ-009 SWAP SHALL exchange indices 001<->100 and 011<->110; indices 000, 010, 101, 111 pass unchanged.
REQ-010 H on qubit k, for each pair (a = index with bit k = 0, b = same index with bit k = 1), SHALL produce a' = ((a+b)*11)>>>4 and b' = ((a-b)*11)>>>4, independently on real and imag parts.
REQ-011 H sums SHALL be formed at `TOTAL_WIDTH+1 bits and products at full width; results SHALL be truncated to the low `TOTAL_WIDTH bits (wrap, no saturation).
REQ-012 CROT SHALL multiply only indices with both control and target bits = 1: S3 indices 011, 111; S5 indices 101, 111; S6 indices 110, 111. All other indices pass through delayed.
REQ-013 Complex multiply by (br, bi): pr = (ar*br - ai*bi)>>>4, pi = (ar*bi + ai*br)>>>4, computed at full product width, then truncated to `TOTAL_WIDTH.
REQ-014 Phase constants: -pi/2 = (0, -16); -pi/4 = (11, -11).
REQ-015 `>>>` SHALL be an arithmetic shift (floor toward -inf); no rounding.
REQ-016 Stage latencies: S1 = 1 cycle; S2-S7 = 3 cycles each; total input-to-output latency SHALL be 19 cycles.
REQ-017 Within each stage, pass-through amplitudes SHALL be delayed by exactly that stage's latency, so all 8 amplitudes of a vector stay aligned.
REQ-018 Pipeline SHALL accept a new vector every cycle (throughput 1/cycle); no backpressure, no stall input.
REQ-019 Datapath registers SHALL capture every cycle regardless of in_valid; in_valid only tags data.
REQ-020 out_valid SHALL equal in_valid delayed through a 19-stage shift register, aligned with the data outputs.
REQ-021 Back-to-back valid vectors SHALL emerge on consecutive cycles, in order, with no interaction between them.

Reset
REQ-022 While rst_n = 0, all pipeline registers, the valid shift register, out_valid and every fXYZ_r/fXYZ_i SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight vectors; none SHALL appear with out_valid = 1 afterward.
REQ-024 After rst_n deasserts, out_valid SHALL remain 0 until 19 cycles after the first cycle with in_valid = 1.

Verification
REQ-025 Reset: hold rst_n = 0 with nonzero inputs -> all outputs 0, out_valid 0; release -> outputs stay 0 while inputs are 0.
REQ-026 Impulse |000>: i000_r = 16, all other inputs 0, in_valid pulsed 1 cycle -> 19 cycles later out_valid = 1 for 1 cycle and all eight fXYZ = (4, 0).
REQ-027 Impulse |001>: i001_r = 16, all others 0 -> f000 = (4,0), f100 = (-5,0), f010 = (0,-5), f110 = (0,4), f001 = (2,-4), f101 = (-3,3), f011 = (-4,-3), f111 = (3,2).
REQ-028 Streaming: |000> and |001> impulses on consecutive cycles with in_valid = 1 -> the REQ-026 result, then the REQ-027 result on the next cycle; out_valid high for exactly 2 cycles.
REQ-029 Mid-flight reset: inject a vector, assert rst_n = 0 at cycle 10 for 2 cycles -> out_valid never rises, outputs stay 0.
REQ-030 Round trip: chain the forward QFT pipeline output into this block -> output matches the original input within +/-3 LSB per component for basis-state inputs of magnitude 16.
